// File: rtl/stream_fifo_checker_if.sv
// Stream-side and host-side handshake bundle for stream_fifo_checker.
// master = FIFO side (consumes generator stream, drives host output); slave = its peer.
interface stream_fifo_checker_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;

    modport master (
        input  data_in,
        input  valid_in,
        input  ready_in,
        output data_out,
        output valid_out
    );

    modport slave (
        output data_in,
        output valid_in,
        output ready_in,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/stream_fifo_checker.sv
// FWFT buffer between a no-backpressure generator stream and a valid/ready host port.
// Define STREAM_FIFO_CHECKER_SEQ_CHECK_EN to add the +1 incrementing-sequence checker.
module stream_fifo_checker #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    stream_fifo_checker_if.master bus,
    output logic [ADDR_W:0]       level_out,
    output logic                  overflow_out,
    output logic [CNT_W-1:0]      drop_cnt_out,
    output logic                  seq_err_out,
    output logic [CNT_W-1:0]      err_cnt_out
);

    localparam int                DATA_W  = 32;
    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                empty, full, rd_en, wr_en, drop;

    // Wrap bit distinguishes full from empty when the address bits coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign rd_en = ~empty & bus.ready_in;
    assign wr_en = bus.valid_in & (~full | rd_en);
    assign drop  = bus.valid_in & full & ~rd_en;

    assign bus.valid_out = ~empty;
    assign bus.data_out  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign level_out     = wr_ptr_q - rd_ptr_q;
    assign overflow_out  = overflow_q;
    assign drop_cnt_out  = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (clear_in) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
    end

`ifdef STREAM_FIFO_CHECKER_SEQ_CHECK_EN
    typedef enum logic {UNARMED, ARMED} seq_state_e;

    seq_state_e          state_q, state_d;
    logic [DATA_W-1:0]   expect_q, expect_d;
    logic                seq_err_q, seq_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    // Every valid word is checked, including those the FIFO drops.
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        seq_err_d = seq_err_q;
        err_cnt_d = err_cnt_q;
        if (clear_in) begin
            state_d   = UNARMED;
            seq_err_d = 1'b0;
            err_cnt_d = '0;
        end else if (bus.valid_in) begin
            expect_d = bus.data_in + 32'd1;
            case (state_q)
                UNARMED: state_d = ARMED;
                ARMED: begin
                    if (bus.data_in != expect_q) begin
                        seq_err_d = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
                default: state_d = UNARMED;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= UNARMED;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        expect_q <= expect_d;
    end

    assign seq_err_out = seq_err_q;
    assign err_cnt_out = err_cnt_q;
`else
    assign seq_err_out = 1'b0;
    assign err_cnt_out = '0;
`endif

endmodule

// File: tb/tb_stream_fifo_checker.sv
// Self-checking bench for stream_fifo_checker: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_stream_fifo_checker;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_MAX = 65535;
`ifdef STREAM_FIFO_CHECKER_SEQ_CHECK_EN
    localparam int SEQ_EN = 1;
`else
    localparam int SEQ_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [ADDR_W:0]   level;
    logic              ovf;
    logic [CNT_W-1:0]  dcnt;
    logic              serr;
    logic [CNT_W-1:0]  ecnt;

    stream_fifo_checker_if #(.DATA_W(32)) bus ();

    stream_fifo_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .clear_in     (clear),
        .bus          (bus),
        .level_out    (level),
        .overflow_out (ovf),
        .drop_cnt_out (dcnt),
        .seq_err_out  (serr),
        .err_cnt_out  (ecnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          m_ovf, m_dcnt, m_serr, m_ecnt, m_armed;
    logic [31:0] m_expect;
    int          dut_peak;

    task automatic model_reset();
        mq.delete(); exp_q.delete(); got_q.delete();
        m_ovf = 0; m_dcnt = 0; m_serr = 0; m_ecnt = 0; m_armed = 0;
        m_expect = 32'd0; dut_peak = 0;
    endtask

    // One clock: drive at negedge, capture handshakes, advance the model, return at next negedge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit c);
        bit rd, wr, full, drop;
        bus.valid_in = v; bus.data_in = d; bus.ready_in = r; clear = c;
        #1;
        if (bus.valid_out === 1'b1 && r) got_q.push_back(bus.data_out);
        full = (mq.size() == DEPTH);
        rd   = r && (mq.size() > 0);
        wr   = v && (!full || rd);
        drop = v && full && !rd;
        if (rd) exp_q.push_back(mq.pop_front());
        if (wr) mq.push_back(d);
        if (c) begin
            m_ovf = 0; m_dcnt = 0; m_serr = 0; m_ecnt = 0; m_armed = 0;
        end else begin
            if (drop) begin
                m_ovf = 1;
                if (m_dcnt < CNT_MAX) m_dcnt++;
            end
            if (v) begin
                if (m_armed != 0 && d != m_expect) begin
                    m_serr = SEQ_EN;
                    if (m_ecnt < CNT_MAX) m_ecnt += SEQ_EN;
                end
                m_armed = 1;
                m_expect = d + 32'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (int'(level) > dut_peak) dut_peak = int'(level);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0; bus.data_in = 32'd0; bus.ready_in = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({bus.valid_out, level, bus.data_out} !== '0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%b level=%0d data=%h required 0", bus.valid_out, level, bus.data_out);
        end
        checks++;
        if ({ovf, dcnt, serr, ecnt} !== '0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b drop=%0d serr=%b ecnt=%0d required 0", ovf, dcnt, serr, ecnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        got_q.delete(); exp_q.delete(); dut_peak = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i), 1'b1, 1'b0);
            if (i == 0) begin
                checks++;
                if (bus.valid_out !== 1'b1 || bus.data_out !== 32'd0) begin
                    errors++;
                    $display("FAIL basic_first: valid=%b data=%h required 1/0", bus.valid_out, bus.data_out);
                end
            end
        end
        idle(3);
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL basic_count: got %0d words required 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 32'(i)) begin
                errors++;
                $display("FAIL basic_order[%0d]: got %h required %h", i, got_q[i], i);
            end
        end
        checks++;
        if (dut_peak != 1) begin
            errors++;
            $display("FAIL basic_peak: got %0d required 1", dut_peak);
        end
        checks++;
        if (ovf !== 1'b0 || dcnt !== '0) begin
            errors++;
            $display("FAIL basic_drop: ovf=%b drop=%0d required 0/0", ovf, dcnt);
        end
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b0);
        checks++;
        if (level !== 5'd16 || dcnt !== 16'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state: level=%0d drop=%0d ovf=%b required 16/4/1", level, dcnt, ovf);
        end
        idle(18);
        checks++;
        if (got_q.size() != 16 || level !== 5'd0) begin
            errors++;
            $display("FAIL overflow_drain: got %0d words level=%0d required 16/0", got_q.size(), level);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 32'(100 + i)) begin
                errors++;
                $display("FAIL overflow_order[%0d]: got %0d required %0d", i, got_q[i], 100 + i);
            end
        end
    endtask

    task automatic test_full_rw();
        logic [CNT_W-1:0] dcnt_before;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0);
        dcnt_before = dcnt;
        checks++;
        if (level !== 5'd16) begin
            errors++;
            $display("FAIL full_fill: level=%0d required 16", level);
        end
        cycle(1'b1, 32'd216, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd16 || dcnt !== dcnt_before || dcnt !== 16'(m_dcnt)) begin
            errors++;
            $display("FAIL full_rw: level=%0d drop=%0d required 16/%0d", level, dcnt, m_dcnt);
        end
        idle(18);
        checks++;
        if (got_q.size() != 17) begin
            errors++;
            $display("FAIL full_rw_count: got %0d words required 17", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 32'(200 + i)) begin
                errors++;
                $display("FAIL full_rw_order[%0d]: got %0d required %0d", i, got_q[i], 200 + i);
            end
        end
    endtask

    task automatic test_seq_wrap();
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0001, 1'b1, 1'b0);
        checks++;
        if (serr !== 1'b0 || ecnt !== '0) begin
            errors++;
            $display("FAIL seq_wrap: serr=%b ecnt=%0d required 0/0", serr, ecnt);
        end
        cycle(1'b1, 32'd5, 1'b1, 1'b0);
        checks++;
        if (serr !== 1'(SEQ_EN) || ecnt !== 16'(SEQ_EN)) begin
            errors++;
            $display("FAIL seq_gap: serr=%b ecnt=%0d required %0d/%0d", serr, ecnt, SEQ_EN, SEQ_EN);
        end
        cycle(1'b1, 32'd6, 1'b1, 1'b0);
        checks++;
        if (serr !== 1'(SEQ_EN) || ecnt !== 16'(SEQ_EN)) begin
            errors++;
            $display("FAIL seq_resync: serr=%b ecnt=%0d required %0d/%0d", serr, ecnt, SEQ_EN, SEQ_EN);
        end
        idle(3);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 17; i++) cycle(1'b1, 32'(300 + i), 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1 || dcnt !== 16'(m_dcnt)) begin
            errors++;
            $display("FAIL clear_pre: ovf=%b drop=%0d required 1/%0d", ovf, dcnt, m_dcnt);
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        checks++;
        if ({ovf, dcnt, serr, ecnt} !== '0 || level !== 5'd16) begin
            errors++;
            $display("FAIL clear_flags: ovf=%b drop=%0d serr=%b ecnt=%0d level=%0d required 0s/16", ovf, dcnt, serr, ecnt, level);
        end
        cycle(1'b1, 32'd40, 1'b1, 1'b0);
        cycle(1'b1, 32'd41, 1'b1, 1'b0);
        checks++;
        if (serr !== 1'b0 || ecnt !== '0 || dcnt !== '0) begin
            errors++;
            $display("FAIL clear_rearm: serr=%b ecnt=%0d drop=%0d required 0/0/0", serr, ecnt, dcnt);
        end
        idle(20);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(500 + i), 1'b0, 1'b0);
        bus.valid_in = 1'b0;
        checks++;
        if (level !== 5'd10) begin
            errors++;
            $display("FAIL midrst_fill: level=%0d required 10", level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b level=%0d required 0/0", bus.valid_out, level);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(600 + i), 1'b1, 1'b0);
        idle(3);
        checks++;
        if (got_q.size() != 20 || dcnt !== '0 || serr !== 1'b0 || ecnt !== '0 || dut_peak != 1) begin
            errors++;
            $display("FAIL midrst_resume: words=%0d drop=%0d serr=%b ecnt=%0d peak=%0d required 20/0/0/0/1",
                     got_q.size(), dcnt, serr, ecnt, dut_peak);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 32'(600 + i)) begin
                errors++;
                $display("FAIL midrst_order[%0d]: got %0d required %0d", i, got_q[i], 600 + i);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] seq = 32'hFFFF_FFF0;
        bit v, r, c;
        logic [31:0] d;
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 30 : 85));
            c = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 7) == 0) d = $urandom;
            else d = seq;
            if (v) seq = d + 32'd1;
            cycle(v, d, r, c);
            checks++;
            if (level !== 5'(mq.size()) || ovf !== 1'(m_ovf) || dcnt !== 16'(m_dcnt) ||
                serr !== 1'(m_serr) || ecnt !== 16'(m_ecnt)) begin
                errors++;
                $display("FAIL random[%0d]: level=%0d ovf=%b drop=%0d serr=%b ecnt=%0d required %0d/%0d/%0d/%0d/%0d",
                         k, level, ovf, dcnt, serr, ecnt, mq.size(), m_ovf, m_dcnt, m_serr, m_ecnt);
            end
        end
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_seq_wrap();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
